// File: rtl/seq_det_1011.sv
// Serial detector for the bit pattern 1011 (MSB first), overlapping matches.
// Moore FSM with a saturating match counter and a window of the last four consumed bits.
module seq_det_1011 (
  input  logic       clk,
  input  logic       clr,
  input  logic       en,
  input  logic       d,
  output logic       found,
  output logic [3:0] count,
  output logic [2:0] state,
  output logic [3:0] last4
);

  typedef enum logic [2:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4
  } state_t;

  state_t     state_q;
  state_t     state_d;
  logic [3:0] count_q;
  logic [3:0] last4_q;

  // State register; count and last4 advance only on enabled steps.
  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q <= S0;
      count_q <= 4'd0;
      last4_q <= 4'd0;
    end else begin
      state_q <= state_d;
      if (en) begin
        last4_q <= {last4_q[2:0], d};
        if (state_d == S4 && count_q != 4'd15) begin
          count_q <= count_q + 4'd1;
        end
      end
    end
  end

  // Next-state logic; unused codes recover to S0 whether or not en is set.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S0: if (en) state_d = d ? S1 : S0;
      S1: if (en) state_d = d ? S1 : S2;
      S2: if (en) state_d = d ? S3 : S0;
      S3: if (en) state_d = d ? S4 : S2;
      S4: if (en) state_d = d ? S1 : S2;
      default: state_d = S0;
    endcase
  end

  // Moore outputs, driven only from registered state.
  always_comb begin
    found = (state_q == S4);
    state = state_q;
    count = count_q;
    last4 = last4_q;
  end

endmodule

// File: tb/tb_seq_det_1011.sv
// Bench for seq_det_1011: constant vector table, directed corner sequences,
// and random steps compared against a history-based reference model.
module tb_seq_det_1011;

  logic       clk;
  logic       clr;
  logic       en;
  logic       d;
  logic       found;
  logic [3:0] count;
  logic [2:0] state;
  logic [3:0] last4;

  int n_checks = 0;
  int n_fail   = 0;

  seq_det_1011 dut (
    .clk   (clk),
    .clr   (clr),
    .en    (en),
    .d     (d),
    .found (found),
    .count (count),
    .state (state),
    .last4 (last4)
  );

  // Clock: 20 ns period.
  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  typedef struct {
    logic       clr;
    logic       en;
    logic       d;
    logic [2:0] st;
    logic       fnd;
    logic [3:0] cnt;
    logic [3:0] l4;
  } vec_t;

  vec_t vecs[$];

  // Reference model: recent consumed bits (newest at back) and the match tally.
  bit m_hist[$];
  int m_matches;
  bit pat[4] = '{1'b1, 1'b0, 1'b1, 1'b1};

  function automatic bit suffix_is_prefix(int k);
    int n;
    n = m_hist.size();
    if (n < k) return 1'b0;
    for (int i = 0; i < k; i++) begin
      if (m_hist[n - k + i] != pat[i]) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic logic [2:0] m_state();
    for (int k = 4; k >= 1; k--) begin
      if (suffix_is_prefix(k)) return 3'(k);
    end
    return 3'd0;
  endfunction

  function automatic logic [3:0] m_last4();
    logic [3:0] v;
    int n;
    v = 4'd0;
    n = m_hist.size();
    for (int i = 0; i < 4 && i < n; i++) v[i] = m_hist[n - 1 - i];
    return v;
  endfunction

  function automatic logic [3:0] m_count();
    return (m_matches > 15) ? 4'd15 : 4'(m_matches);
  endfunction

  task automatic model_update(input logic c, input logic e, input logic dv);
    if (!c) begin
      m_hist.delete();
      m_matches = 0;
    end else if (e) begin
      m_hist.push_back(dv);
      if (m_hist.size() > 4) void'(m_hist.pop_front());
      if (m_state() == 3'd4) m_matches++;
    end
  endtask

  task automatic chk(input string name, input logic [3:0] got, input logic [3:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".state"}, {1'b0, state}, {1'b0, m_state()});
    chk({tag, ".found"}, {3'b0, found}, {3'b0, (m_state() == 3'd4)});
    chk({tag, ".count"}, count, m_count());
    chk({tag, ".last4"}, last4, m_last4());
  endtask

  // Called at a negedge: drive inputs, take one rising edge, return at the next negedge.
  task automatic step(input logic c, input logic e, input logic dv);
    clr = c;
    en  = e;
    d   = dv;
    @(posedge clk);
    model_update(c, e, dv);
    @(negedge clk);
  endtask

  task automatic feed(input logic [15:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) step(1'b1, 1'b1, bits[i]);
  endtask

  function automatic vec_t mk(logic c, logic e, logic dv, logic [2:0] st, logic f,
                              logic [3:0] cn, logic [3:0] l4);
    vec_t v;
    v.clr = c; v.en = e; v.d = dv; v.st = st; v.fnd = f; v.cnt = cn; v.l4 = l4;
    return v;
  endfunction

  initial begin
    clr = 1'b0;
    en  = 1'b0;
    d   = 1'b0;

    // Reset with en=1,d=1, basic match, then d=0.
    vecs.push_back(mk(0, 1, 1, 3'd0, 0, 4'd0, 4'b0000));
    vecs.push_back(mk(1, 1, 1, 3'd1, 0, 4'd0, 4'b0001));
    vecs.push_back(mk(1, 1, 0, 3'd2, 0, 4'd0, 4'b0010));
    vecs.push_back(mk(1, 1, 1, 3'd3, 0, 4'd0, 4'b0101));
    vecs.push_back(mk(1, 1, 1, 3'd4, 1, 4'd1, 4'b1011));
    vecs.push_back(mk(1, 1, 0, 3'd2, 0, 4'd1, 4'b0110));
    // Overlap: 1011011.
    vecs.push_back(mk(0, 0, 0, 3'd0, 0, 4'd0, 4'b0000));
    vecs.push_back(mk(1, 1, 1, 3'd1, 0, 4'd0, 4'b0001));
    vecs.push_back(mk(1, 1, 0, 3'd2, 0, 4'd0, 4'b0010));
    vecs.push_back(mk(1, 1, 1, 3'd3, 0, 4'd0, 4'b0101));
    vecs.push_back(mk(1, 1, 1, 3'd4, 1, 4'd1, 4'b1011));
    vecs.push_back(mk(1, 1, 0, 3'd2, 0, 4'd1, 4'b0110));
    vecs.push_back(mk(1, 1, 1, 3'd3, 0, 4'd1, 4'b1101));
    vecs.push_back(mk(1, 1, 1, 3'd4, 1, 4'd2, 4'b1011));
    // No false match: 1110010.
    vecs.push_back(mk(0, 1, 0, 3'd0, 0, 4'd0, 4'b0000));
    vecs.push_back(mk(1, 1, 1, 3'd1, 0, 4'd0, 4'b0001));
    vecs.push_back(mk(1, 1, 1, 3'd1, 0, 4'd0, 4'b0011));
    vecs.push_back(mk(1, 1, 1, 3'd1, 0, 4'd0, 4'b0111));
    vecs.push_back(mk(1, 1, 0, 3'd2, 0, 4'd0, 4'b1110));
    vecs.push_back(mk(1, 1, 0, 3'd0, 0, 4'd0, 4'b1100));
    vecs.push_back(mk(1, 1, 1, 3'd1, 0, 4'd0, 4'b1001));
    vecs.push_back(mk(1, 1, 0, 3'd2, 0, 4'd0, 4'b0010));

    @(negedge clk);
    foreach (vecs[i]) begin
      step(vecs[i].clr, vecs[i].en, vecs[i].d);
      chk($sformatf("vec%0d.state", i), {1'b0, state}, {1'b0, vecs[i].st});
      chk($sformatf("vec%0d.found", i), {3'b0, found}, {3'b0, vecs[i].fnd});
      chk($sformatf("vec%0d.count", i), count, vecs[i].cnt);
      chk($sformatf("vec%0d.last4", i), last4, vecs[i].l4);
    end

    // Enable hold in S3.
    step(1'b0, 1'b0, 1'b0);
    feed(16'b101, 3);
    chk("hold.pre_state", {1'b0, state}, 4'd3);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b1);
      chk("hold.state", {1'b0, state}, 4'd3);
      chk("hold.found", {3'b0, found}, 4'd0);
      chk("hold.count", count, 4'd0);
      chk("hold.last4", last4, 4'b0101);
    end
    step(1'b1, 1'b1, 1'b1);
    chk("hold.resume_state", {1'b0, state}, 4'd4);
    chk("hold.resume_found", {3'b0, found}, 4'd1);
    chk("hold.resume_count", count, 4'd1);

    // Saturation: "1" then 20 x "011".
    step(1'b0, 1'b0, 1'b0);
    feed(16'b1, 1);
    for (int k = 1; k <= 20; k++) begin
      feed(16'b011, 3);
      chk("sat.found", {3'b0, found}, 4'd1);
      chk("sat.count", count, (k > 15) ? 4'd15 : 4'(k));
    end
    step(1'b1, 1'b1, 1'b0);
    chk("sat.after_found", {3'b0, found}, 4'd0);
    chk("sat.after_count", count, 4'd15);

    // Reset mid-operation from S3 with count=2.
    step(1'b0, 1'b0, 1'b0);
    feed(16'b1011011, 7);
    feed(16'b01, 2);
    chk("rst_mid.pre_state", {1'b0, state}, 4'd3);
    chk("rst_mid.pre_count", count, 4'd2);
    // clr dropping between edges must not disturb outputs.
    clr = 1'b0;
    #5;
    chk("async.state", {1'b0, state}, 4'd3);
    chk("async.count", count, 4'd2);
    chk("async.last4", last4, 4'b1101);
    step(1'b0, 1'b1, 1'b1);
    chk("rst_mid.state", {1'b0, state}, 4'd0);
    chk("rst_mid.count", count, 4'd0);
    chk("rst_mid.last4", last4, 4'b0000);
    feed(16'b1011, 4);
    chk("rst_mid.recount", count, 4'd1);
    chk("rst_mid.found", {3'b0, found}, 4'd1);

    // Random steps against the reference model.
    step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 39) != 0), ($urandom_range(0, 3) != 0), 1'($urandom));
      chk_model($sformatf("rand%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
